// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings and constants for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam logic [3:0] FETCH_MASK = 4'hF;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store, one transaction at a time
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [3:0]    d_mask,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [3:0]    mem_mask,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_mw
);
  state_t state, state_nx;
  owner_t owner;
  logic [3:0] starve_cnt;
  logic drop;
  logic if_ok, grant, pick_if, contested, kill, done, if_keep;
  assign if_ok     = if_req & ~flush;
  assign grant     = (state == IDLE) & (d_req | if_ok);
  assign pick_if   = if_ok & (~d_req | (starve_cnt >= 4'(STARVE_MAX)));
  assign contested = d_req & if_ok;
  assign kill      = flush & (owner == OWN_IF) & ((state == REQ) | (state == WAIT));
  assign done      = (state == WAIT) & mem_rvalid;
  // a flush coinciding with the response kills it just like an earlier one
  assign if_keep   = done & (owner == OWN_IF) & ~drop & ~flush;
  assign stall_f   = if_req & ~if_valid;
  assign stall_mw  = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = grant ? REQ : IDLE;
      REQ:  state_nx = mem_gnt ? WAIT : REQ;
      WAIT: state_nx = mem_rvalid ? RESP : WAIT;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      owner      <= OWN_IF;
      starve_cnt <= '0;
      drop       <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_mask   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      mem_req  <= state_nx == REQ;
      if_valid <= if_keep;
      d_valid  <= done & (owner == OWN_D);
      drop     <= (state_nx == IDLE) ? 1'b0 : drop | kill;
      if (if_keep) if_rdata <= mem_rdata;
      if (done & (owner == OWN_D)) d_rdata <= mem_rdata;
      if (grant) begin
        owner      <= pick_if ? OWN_IF : OWN_D;
        mem_wr     <= ~pick_if & d_wr;
        mem_mask   <= pick_if ? FETCH_MASK : d_mask;
        mem_addr   <= pick_if ? if_addr : d_addr;
        mem_wdata  <= pick_if ? '0 : d_wdata;
        starve_cnt <= pick_if ? 4'd0 : contested ? starve_cnt + 4'd1 : starve_cnt;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural memory responder and requester models
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32;
  typedef struct { logic wr; logic [3:0] mask; logic [31:0] addr; logic [31:0] wdata; } txn_t;

  logic clk = 0, rst = 1, flush = 0, if_req = 0, d_req = 0, d_wr = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0, mem_addr;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0, if_rdata, d_rdata, mem_wdata;
  logic [3:0] d_mask = '0, mem_mask;
  logic if_valid, d_valid, mem_req, mem_wr, stall_f, stall_mw;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_wr(d_wr), .d_mask(d_mask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_mask(mem_mask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_mw(stall_mw)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [logic [31:0]];
  txn_t d_pend[$], gnt_log[$], cur;
  logic [31:0] if_exp[$], d_exp[$];
  bit vlog[$];
  bit pend = 0;
  int gnt_stall = 0, rv_delay = 0, rv_cnt = 0;
  int chk = 0, pass_n = 0, if_vcnt = 0, d_vcnt = 0;
  logic [31:0] last_if = '0;
  logic last_stall_f = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : (a ^ 32'hC0DE0000);
  endfunction

  function automatic txn_t mk(input logic wr, input logic [3:0] m, input logic [31:0] a, input logic [31:0] w);
    txn_t t;
    t.wr = wr; t.mask = m; t.addr = a; t.wdata = w;
    return t;
  endfunction

  task automatic present_d(input txn_t t);
    if (d_req) d_pend.push_back(t);
    else begin
      d_req = 1; d_wr = t.wr; d_mask = t.mask; d_addr = t.addr; d_wdata = t.wdata;
      d_exp.push_back(t.wr ? 32'h0 : rd(t.addr));
    end
  endtask

  task automatic present_if(input logic [31:0] a);
    if_req = 1; if_addr = a;
    if_exp.push_back(rd(a));
  endtask

  // one clock: requesters, scoreboard pops, then the memory responder reacts to what it sees
  task automatic step();
    logic [31:0] e, w;
    txn_t t;
    @(posedge clk); #1;
    if (!d_req && d_pend.size() > 0) begin
      t = d_pend.pop_front();
      present_d(t);
    end
    last_stall_f = stall_f;
    if (d_valid) begin
      chk++;
      if (d_exp.size() == 0) $display("FAIL d_valid_unexpected: got pulse rdata %h, want none", d_rdata);
      else begin
        e = d_exp.pop_front();
        if (d_rdata !== e) $display("FAIL d_rdata: got %h want %h", d_rdata, e);
        else pass_n++;
      end
      d_req = 0; d_vcnt++; vlog.push_back(1);
    end
    if (if_valid) begin
      chk++;
      if (if_exp.size() == 0) $display("FAIL if_valid_unexpected: got pulse rdata %h, want none", if_rdata);
      else begin
        e = if_exp.pop_front();
        last_if = e;
        if (if_rdata !== e) $display("FAIL if_rdata: got %h want %h", if_rdata, e);
        else pass_n++;
      end
      if_req = 0; if_vcnt++; vlog.push_back(0);
    end
    mem_gnt = 0; mem_rvalid = 0;
    if (pend) begin
      if (rv_cnt > 0) rv_cnt--;
      else begin
        mem_rvalid = 1;
        mem_rdata = cur.wr ? 32'h0 : rd(cur.addr);
        if (cur.wr) begin
          w = rd(cur.addr);
          for (int i = 0; i < 4; i++) if (cur.mask[i]) w[8*i +: 8] = cur.wdata[8*i +: 8];
          ram[cur.addr] = w;
        end
        pend = 0;
      end
    end else if (mem_req) begin
      if (gnt_stall > 0) gnt_stall--;
      else begin
        mem_gnt = 1;
        cur = mk(mem_wr, mem_mask, mem_addr, mem_wdata);
        gnt_log.push_back(cur);
        pend = 1; rv_cnt = rv_delay;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((if_req || d_req || d_pend.size() > 0 || pend) && n < 300) begin step(); n++; end
    if (n >= 300) begin chk++; $display("FAIL wait_idle: got timeout after %0d cycles, want idle", n); end
    step(); step();
  endtask

  task automatic wait_pend();
    int n = 0;
    while (!pend && n < 40) begin step(); n++; end
    if (!pend) begin chk++; $display("FAIL wait_grant: got no grant, want grant"); end
  endtask

  task automatic test_reset();
    #2 rst = 0; if_req = 1;
    repeat (2) @(posedge clk);
    #1;
    chk++;
    if ({mem_req, mem_wr, mem_mask, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata} !== '0)
      $display("FAIL reset_outputs: got req %b wr %b mask %h addr %h", mem_req, mem_wr, mem_mask, mem_addr);
    else pass_n++;
    chk++;
    if (stall_f !== 1'b1) $display("FAIL reset_stall_f: got %b want 1", stall_f); else pass_n++;
    if_req = 0;
    @(negedge clk) rst = 1;
  endtask

  task automatic test_basic_fetch();
    ram[32'h10] = 32'h00500093;
    present_if(32'h10); #1;
    chk++; if (stall_f !== 1'b1) $display("FAIL c0_stall_f: got %b want 1", stall_f); else pass_n++;
    step();
    chk++;
    if ({mem_req, mem_wr, mem_mask, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10})
      $display("FAIL c1_mem: got req %b wr %b mask %h addr %h want 1 0 f 10", mem_req, mem_wr, mem_mask, mem_addr);
    else pass_n++;
    chk++; if (stall_f !== 1'b1) $display("FAIL c1_stall_f: got %b want 1", stall_f); else pass_n++;
    step();
    chk++;
    if ({mem_req, if_valid, stall_f} !== 3'b001)
      $display("FAIL c2_wait: got req %b valid %b stall %b want 0 0 1", mem_req, if_valid, stall_f);
    else pass_n++;
    step();
    chk++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h00500093 || last_stall_f !== 1'b0)
      $display("FAIL c3_valid: got valid %b rdata %h stall %b want 1 00500093 0", if_valid, if_rdata, last_stall_f);
    else pass_n++;
    step();
    chk++; if (if_valid !== 1'b0) $display("FAIL c4_pulse: got %b want 0", if_valid); else pass_n++;
    wait_idle();
  endtask

  task automatic test_data_priority();
    gnt_log.delete(); vlog.delete();
    present_if(32'h20);
    present_d(mk(1, 4'b0011, 32'h200, 32'hABCD));
    wait_idle();
    chk++;
    if (gnt_log.size() != 2 || gnt_log[0].wr !== 1'b1 || gnt_log[0].mask !== 4'b0011 ||
        gnt_log[0].addr !== 32'h200 || gnt_log[0].wdata !== 32'hABCD)
      $display("FAIL prio_first: got n %0d wr %b mask %h addr %h want store 3 200", gnt_log.size(),
               gnt_log[0].wr, gnt_log[0].mask, gnt_log[0].addr);
    else pass_n++;
    chk++;
    if (gnt_log[1].addr !== 32'h20 || gnt_log[1].mask !== 4'hF || gnt_log[1].wr !== 1'b0)
      $display("FAIL prio_second: got addr %h mask %h wr %b want 20 f 0", gnt_log[1].addr, gnt_log[1].mask, gnt_log[1].wr);
    else pass_n++;
    chk++;
    if (vlog.size() != 2 || vlog[0] != 1 || vlog[1] != 0)
      $display("FAIL prio_valid_order: got n %0d first %0d want d then if", vlog.size(), vlog[0]);
    else pass_n++;
    chk++;
    if (rd(32'h200) !== 32'hC0DEABCD) $display("FAIL store_mask: got %h want c0deabcd", rd(32'h200)); else pass_n++;
  endtask

  task automatic test_starvation();
    logic [12:0] got = '0;
    gnt_log.delete();
    present_if(32'h40);
    for (int i = 0; i < 6; i++) present_d(mk(0, 4'hF, 32'h100 + 4 * i, 0));
    wait_idle();
    present_if(32'h44);
    for (int i = 0; i < 5; i++) present_d(mk(0, 4'hF, 32'h180 + 4 * i, 0));
    wait_idle();
    for (int i = 0; i < 13 && i < gnt_log.size(); i++) got[12 - i] = gnt_log[i].addr >= 32'h100;
    chk++;
    if (gnt_log.size() != 13 || got !== 13'b1111011111101)
      $display("FAIL starve_order: got n %0d pattern %b want 13 1111011111101", gnt_log.size(), got);
    else pass_n++;
  endtask

  task automatic test_flush();
    int v0 = if_vcnt;
    logic [31:0] keep = last_if;
    rv_delay = 2;
    present_if(32'h50);
    wait_pend(); step();
    flush = 1; if_req = 0; void'(if_exp.pop_back());
    step(); flush = 0;
    wait_idle();
    chk++;
    if (if_vcnt != v0 || if_rdata !== keep)
      $display("FAIL flush_wait: got pulses %0d rdata %h want %0d %h", if_vcnt - v0, if_rdata, 0, keep);
    else pass_n++;
    rv_delay = 0;
    present_if(32'h58);
    for (int n = 0; n < 20 && !mem_rvalid; n++) step();
    flush = 1; if_req = 0; void'(if_exp.pop_back());
    step(); flush = 0;
    wait_idle();
    chk++;
    if (if_vcnt != v0 || if_rdata !== keep)
      $display("FAIL flush_same_cycle: got pulses %0d rdata %h want 0 %h", if_vcnt - v0, if_rdata, keep);
    else pass_n++;
    present_if(32'h5C);
    wait_idle();
    chk++;
    if (if_vcnt != v0 + 1 || if_rdata !== rd(32'h5C))
      $display("FAIL flush_refetch: got pulses %0d rdata %h want 1 %h", if_vcnt - v0, if_rdata, rd(32'h5C));
    else pass_n++;
  endtask

  task automatic test_gnt_stall();
    int reqc = 0, n = 0, v0;
    gnt_stall = 5;
    present_d(mk(1, 4'b1100, 32'h300, 32'h11223344));
    while (d_req && n < 40) begin
      step(); n++;
      if (mem_req) begin
        reqc++; chk++;
        if ({mem_wr, mem_mask, mem_addr, mem_wdata} !== {1'b1, 4'b1100, 32'h300, 32'h11223344})
          $display("FAIL stall_fields: got wr %b mask %h addr %h wdata %h", mem_wr, mem_mask, mem_addr, mem_wdata);
        else pass_n++;
      end
    end
    wait_idle();
    chk++; if (reqc != 6) $display("FAIL stall_req_cycles: got %0d want 6", reqc); else pass_n++;
    v0 = d_vcnt; rv_delay = 2;
    present_d(mk(1, 4'hF, 32'h304, 32'hDEADBEEF));
    wait_pend(); step();
    flush = 1; step(); flush = 0;
    wait_idle(); rv_delay = 0;
    chk++;
    if (d_vcnt != v0 + 1 || rd(32'h304) !== 32'hDEADBEEF)
      $display("FAIL flush_store: got pulses %0d mem %h want 1 deadbeef", d_vcnt - v0, rd(32'h304));
    else pass_n++;
  endtask

  task automatic test_reset_mid();
    int v0 = d_vcnt, bad = 0;
    rv_delay = 3;
    present_d(mk(0, 4'hF, 32'h400, 0));
    wait_pend(); step();
    #2 rst = 0; #1;
    chk++;
    if ({mem_req, mem_wr, mem_mask, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata} !== '0)
      $display("FAIL midreset_outputs: got addr %h if_rdata %h d_rdata %h want 0", mem_addr, if_rdata, d_rdata);
    else pass_n++;
    d_req = 0; d_exp.delete(); d_pend.delete(); rv_delay = 0;
    @(negedge clk) rst = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req || d_valid || if_valid) bad++;
    end
    chk++;
    if (bad != 0 || d_vcnt != v0 || d_rdata !== 32'h0)
      $display("FAIL stray_rvalid: got activity %0d pulses %0d rdata %h want 0 0 0", bad, d_vcnt - v0, d_rdata);
    else pass_n++;
    present_d(mk(0, 4'hF, 32'h404, 0));
    step();
    chk++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h404)
      $display("FAIL post_reset_grant: got req %b addr %h want 1 404", mem_req, mem_addr);
    else pass_n++;
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_data_priority();
    test_starvation();
    test_flush();
    test_gnt_stall();
    test_reset_mid();
    chk++;
    if (if_exp.size() != 0 || d_exp.size() != 0)
      $display("FAIL leftover: got if %0d d %0d pending responses want 0 0", if_exp.size(), d_exp.size());
    else pass_n++;
    $display("%0d/%0d checks passed", pass_n, chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction reads) and the memory/writeback stage load-store path (reads and writes).
- Sequences one outstanding memory transaction at a time and arbitrates with data priority, plus a starvation guard for fetch.
- Drives per-requester stall signals into the pipeline and hazard logic.
- Discards fetch responses killed by a branch flush.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins the next contested arbitration (must be 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  branch flush from hazard unit; cancels the current fetch
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  load/store request; held with its fields stable until d_valid
- d_wr  in  1  1 = store
- d_mask  in  4  byte enables for stores
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid with d_valid
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_req  out  1  memory request
- mem_wr  out  1  memory write
- mem_mask  out  4  memory byte enables (4'hF for fetch)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_gnt  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  memory response/ack; only meaningful in WAIT
- mem_rdata  in  DW  memory read data
- stall_f  out  1  stall PC and fetch register
- stall_mw  out  1  stall MW stage

Behaviour:
- FSM states IDLE, REQ, WAIT, RESP plus a registered owner (IF or D).
- Reset: state IDLE, owner IF, starve_cnt 0, drop 0. Every registered output is 0: mem_req, mem_wr, mem_mask, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata.
- Reset mid-transaction aborts to IDLE immediately. No response is delivered afterwards.
- IDLE arbitration:
  - Only d_req: owner D.
  - Only if_req with flush low: owner IF.
  - Both, starve_cnt < STARVE_MAX: owner D, starve_cnt++.
  - Both, starve_cnt == STARVE_MAX: owner IF.
  - Any IF grant clears starve_cnt.
  - if_req together with flush in IDLE is not granted that cycle.
  - On any grant, move to REQ and latch the owner's address, write, mask and wdata into the mem_* registers.
- REQ: mem_req = 1 with fields stable. Move to WAIT on mem_gnt; otherwise hold. Requests are never withdrawn.
- WAIT: mem_req = 0. On mem_rvalid, capture mem_rdata into the owner's rdata register and move to RESP. mem_rvalid in IDLE, REQ or RESP is ignored.
- RESP: pulse the owner's valid for exactly one cycle, then return to IDLE.
  - If drop = 1, if_valid is suppressed and if_rdata is left unchanged.
  - drop clears on entering IDLE.
- Flush:
  - Owner IF in REQ or WAIT: set drop; the transaction still completes on the memory side.
  - flush in the same cycle as mem_rvalid: response dropped.
  - flush with owner D: no effect.
- Latency: request seen in IDLE at cycle 0, REQ at cycle 1, gnt at cycle 1 gives WAIT at cycle 2, rvalid at cycle 2 gives valid at cycle 3. Minimum 4 cycles from request to IDLE.
- Requesters may present a new request in the cycle after their valid. IDLE samples it, so there is no double-grant.
- stall_f = if_req & ~(if_valid) (combinational); same form for stall_mw with d_req/d_valid.
- starve_cnt saturates at STARVE_MAX; its width is 4 bits.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, REQ, WAIT, RESP}
  - owner enum {OWN_IF, OWN_D}
  - constant FETCH_MASK = 4'hF
- No sub-module: the FSM, arbitration and counter fit in one module of about 200 lines.

Test Plan:
- Reset, then if_req addr 0x10 with mem_gnt=1 and mem_rvalid one cycle later (rdata 0x00500093) -> mem_req at cycle 1 with addr 0x10, mask F; if_valid at cycle 3 with if_rdata 0x00500093; stall_f=1 for cycles 0-2.
- if_req and d_req (store, addr 0x200, mask 4'b0011, wdata 0xABCD) both held from cycle 0 -> data served first with mem_wr=1, mask 3; d_valid before fetch; fetch served next.
- d_req issued back-to-back continuously with if_req held, STARVE_MAX=4 -> exactly 4 data grants, then a fetch grant; starve_cnt returns to 0.
- Fetch in WAIT, flush pulsed, then mem_rvalid -> if_valid stays 0 and if_rdata unchanged; next if_req (new PC) is served normally.
- mem_gnt held low for 5 cycles in REQ -> mem_req and fields stable all 5 cycles; flush pulsed during a store -> no effect, d_valid still pulses.
- rst driven low while in WAIT, then mem_rvalid arrives after release -> all outputs 0, state IDLE, stray rvalid ignored.
